// File: rtl/uart_rx_if.sv
// Serial line and receive-side outputs of the 8N1 UART receiver.
// Latency: none (wiring only).
// Backpressure: none; the consumer must take each o_Rx_DV strobe as it occurs.
//
// Ports:
//   i_Rx_Serial     serial line into the receiver, idles high
//   o_Rx_DV         one-cycle strobe, o_Rx_Byte valid while high
//   o_Rx_Byte       last good byte, held until the next good byte
//   o_Rx_Active     high while a frame is in progress
//   o_Rx_Frame_Err  one-cycle strobe when a stop bit is sampled low
// The master modport is the receiver; the slave modport is the line driver / byte consumer.
interface uart_rx_if;
  logic       i_Rx_Serial;
  logic       o_Rx_DV;
  logic [7:0] o_Rx_Byte;
  logic       o_Rx_Active;
  logic       o_Rx_Frame_Err;

  modport master (
    input  i_Rx_Serial,
    output o_Rx_DV,
    output o_Rx_Byte,
    output o_Rx_Active,
    output o_Rx_Frame_Err
  );

  modport slave (
    output i_Rx_Serial,
    input  o_Rx_DV,
    input  o_Rx_Byte,
    input  o_Rx_Active,
    input  o_Rx_Frame_Err
  );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling, one-cycle byte strobe, framing-error strobe.
// Latency: o_Rx_DV rises about 2 + HALF_BIT + 9*CLKS_PER_BIT cycles after the start edge.
// Backpressure: none; every strobe is a single cycle and is never repeated.
//
// Ports:
//   i_Clock  system clock, rising edge
//   i_Reset  asynchronous active-high reset
//   rx       uart_rx_if.master: i_Rx_Serial in; o_Rx_DV, o_Rx_Byte,
//            o_Rx_Active, o_Rx_Frame_Err out (all outputs registered)
module uart_rx #(
  parameter logic [9:0] CLKS_PER_BIT = 10'd860  // f(i_Clock)/baud, legal 4..1023
) (
  input  logic     i_Clock,
  input  logic     i_Reset,
  uart_rx_if.master rx
);

  // Start-bit mid-point and the last count of a full bit period.
  localparam logic [9:0] HALF_BIT = (CLKS_PER_BIT - 10'd1) / 10'd2;
  localparam logic [9:0] LAST_CNT = CLKS_PER_BIT - 10'd1;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    START      = 3'd1,
    DATA       = 3'd2,
    STOP       = 3'd3,
    CLEANUP    = 3'd4,
    BREAK_WAIT = 3'd5
  } state_t;

  state_t     state;
  logic       rx_meta;    // first synchronizer stage, may be metastable
  logic       rx_s;       // synchronized line, two cycles behind the pin
  logic [9:0] clk_cnt;
  logic [2:0] bit_idx;
  logic [7:0] shift_reg;

  // Two-flop synchronizer. Resets to the idle (high) line level so that
  // leaving reset never looks like a start edge.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx.i_Rx_Serial;
      rx_s    <= rx_meta;
    end
  end

  // Receive state machine with registered outputs. The two strobes are
  // cleared every cycle and set only on the STOP-exit edge, so each lasts
  // exactly one cycle and they can never coincide.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state             <= IDLE;
      clk_cnt           <= 10'd0;
      bit_idx           <= 3'd0;
      shift_reg         <= 8'd0;
      rx.o_Rx_DV        <= 1'b0;
      rx.o_Rx_Byte      <= 8'd0;
      rx.o_Rx_Active    <= 1'b0;
      rx.o_Rx_Frame_Err <= 1'b0;
    end else begin
      rx.o_Rx_DV        <= 1'b0;
      rx.o_Rx_Frame_Err <= 1'b0;

      case (state)
        IDLE: begin
          clk_cnt <= 10'd0;
          bit_idx <= 3'd0;
          if (!rx_s) begin
            state          <= START;
            rx.o_Rx_Active <= 1'b1;
          end
        end

        // Re-check the line at the start-bit centre; a high line here means
        // the falling edge was a glitch and the frame is dropped silently.
        START: begin
          if (clk_cnt == HALF_BIT) begin
            clk_cnt <= 10'd0;
            if (!rx_s) begin
              state <= DATA;
            end else begin
              state          <= IDLE;
              rx.o_Rx_Active <= 1'b0;
            end
          end else begin
            clk_cnt <= clk_cnt + 10'd1;
          end
        end

        // Counting from the start-bit centre keeps every data sample at the
        // centre of its bit cell, LSB first.
        DATA: begin
          if (clk_cnt == LAST_CNT) begin
            clk_cnt            <= 10'd0;
            shift_reg[bit_idx] <= rx_s;
            if (bit_idx != 3'd7) begin
              bit_idx <= bit_idx + 3'd1;
            end else begin
              bit_idx <= 3'd0;
              state   <= STOP;
            end
          end else begin
            clk_cnt <= clk_cnt + 10'd1;
          end
        end

        // A low stop bit leaves o_Rx_Byte untouched so the consumer never
        // sees a corrupted byte; the line must return high before the next
        // frame can start, which swallows a break as one error.
        STOP: begin
          if (clk_cnt == LAST_CNT) begin
            clk_cnt        <= 10'd0;
            rx.o_Rx_Active <= 1'b0;
            if (rx_s) begin
              rx.o_Rx_Byte <= shift_reg;
              rx.o_Rx_DV   <= 1'b1;
              state        <= CLEANUP;
            end else begin
              rx.o_Rx_Frame_Err <= 1'b1;
              state             <= BREAK_WAIT;
            end
          end else begin
            clk_cnt <= clk_cnt + 10'd1;
          end
        end

        CLEANUP: begin
          clk_cnt <= 10'd0;
          state   <= IDLE;
        end

        BREAK_WAIT: begin
          clk_cnt <= 10'd0;
          if (rx_s) begin
            state <= IDLE;
          end
        end

        default: begin
          state          <= IDLE;
          clk_cnt        <= 10'd0;
          bit_idx        <= 3'd0;
          rx.o_Rx_Active <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx at 8 clocks per bit: directed frames, scoreboard checking.
// Clock period is 100 time units so that a +2% bit time (816) stays integral.
module tb_uart_rx;

  localparam int CPB   = 8;
  localparam int TCLK  = 100;
  localparam int TBIT  = CPB * TCLK;

  typedef struct packed {
    logic       is_err;
    logic [7:0] dat;
  } exp_t;

  logic clk;
  logic rst;
  uart_rx_if rx_if ();

  uart_rx #(.CLKS_PER_BIT(10'd8)) dut (
    .i_Clock (clk),
    .i_Reset (rst),
    .rx      (rx_if)
  );

  initial begin
    clk = 1'b0;
    forever #(TCLK / 2) clk = ~clk;
  end

  int   total = 0;
  int   bad   = 0;
  int   n_dv_seen = 0;
  int   n_dv_exp  = 0;
  exp_t sb_q[$];
  logic [7:0] last_good;
  logic prev_dv;
  logic prev_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Drive one frame onto the pin; bt is the transmitter's bit time.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int bt);
    exp_t e;
    if (stop_bit) begin
      e.is_err = 1'b0;
      e.dat    = b;
      last_good = b;
      n_dv_exp++;
    end else begin
      e.is_err = 1'b1;
      e.dat    = last_good;
    end
    sb_q.push_back(e);
    rx_if.i_Rx_Serial = 1'b0;
    #(bt);
    for (int i = 0; i < 8; i++) begin
      rx_if.i_Rx_Serial = b[i];
      #(bt);
    end
    rx_if.i_Rx_Serial = stop_bit;
    #(bt);
  endtask

  task automatic idle_bits(input int n);
    rx_if.i_Rx_Serial = 1'b1;
    #(n * TBIT);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a strobe.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && (rx_if.o_Rx_DV || rx_if.o_Rx_Frame_Err)) begin
      chk("dv_err_exclusive", {31'd0, rx_if.o_Rx_DV & rx_if.o_Rx_Frame_Err}, 32'd0);
      chk("strobe_one_cycle",
          {31'd0, (rx_if.o_Rx_DV & prev_dv) | (rx_if.o_Rx_Frame_Err & prev_err)}, 32'd0);
      if (rx_if.o_Rx_DV) n_dv_seen++;
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_strobe: dv=%0b err=%0b byte=%02h, required no output",
                 rx_if.o_Rx_DV, rx_if.o_Rx_Frame_Err, rx_if.o_Rx_Byte);
      end else begin
        e = sb_q.pop_front();
        chk("strobe_kind_is_err", {31'd0, rx_if.o_Rx_Frame_Err}, {31'd0, e.is_err});
        chk("rx_byte", {24'd0, rx_if.o_Rx_Byte}, {24'd0, e.dat});
      end
    end
    prev_dv  <= rx_if.o_Rx_DV;
    prev_err <= rx_if.o_Rx_Frame_Err;
  end

  initial begin
    logic seen;
    prev_dv  = 1'b0;
    prev_err = 1'b0;
    last_good = 8'h00;
    rx_if.i_Rx_Serial = 1'b1;
    rst = 1'b1;
    #1;
    chk("reset_dv",     {31'd0, rx_if.o_Rx_DV},        32'd0);
    chk("reset_byte",   {24'd0, rx_if.o_Rx_Byte},      32'd0);
    chk("reset_active", {31'd0, rx_if.o_Rx_Active},    32'd0);
    chk("reset_ferr",   {31'd0, rx_if.o_Rx_Frame_Err}, 32'd0);
    #(3 * TCLK + 30);
    rst = 1'b0;
    idle_bits(2);

    // Single good byte.
    send_frame(8'hA5, 1'b1, TBIT);
    idle_bits(2);
    chk("active_after_frame", {31'd0, rx_if.o_Rx_Active}, 32'd0);

    // Back-to-back frames, no idle gap.
    send_frame(8'h00, 1'b1, TBIT);
    send_frame(8'hFF, 1'b1, TBIT);
    send_frame(8'h3C, 1'b1, TBIT);
    idle_bits(3);

    // Start glitch: 3 cycles low.
    @(negedge clk);
    rx_if.i_Rx_Serial = 1'b0;
    repeat (3) @(posedge clk);
    rx_if.i_Rx_Serial = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rx_if.o_Rx_Active) seen = 1'b1;
    end
    chk("glitch_active_seen", {31'd0, seen}, 32'd1);
    repeat (10) @(negedge clk);
    chk("glitch_active_clear", {31'd0, rx_if.o_Rx_Active}, 32'd0);
    idle_bits(1);
    send_frame(8'h81, 1'b1, TBIT);
    idle_bits(2);

    // Framing error followed by a held-low break.
    send_frame(8'h55, 1'b0, TBIT);
    rx_if.i_Rx_Serial = 1'b0;
    #(40 * TCLK);
    idle_bits(2);
    send_frame(8'h12, 1'b1, TBIT);
    idle_bits(3);

    // Reset during data bit 4 of 0xC3; transmitter abandons the frame.
    rx_if.i_Rx_Serial = 1'b0;
    #(TBIT);
    for (int i = 0; i < 4; i++) begin
      rx_if.i_Rx_Serial = 1'(8'hC3 >> i);
      #(TBIT);
    end
    rx_if.i_Rx_Serial = 1'b0;  // bit 4 of 0xC3
    #(TBIT / 2 + 30);
    rst = 1'b1;
    rx_if.i_Rx_Serial = 1'b1;
    #1;
    chk("midreset_dv",     {31'd0, rx_if.o_Rx_DV},        32'd0);
    chk("midreset_byte",   {24'd0, rx_if.o_Rx_Byte},      32'd0);
    chk("midreset_active", {31'd0, rx_if.o_Rx_Active},    32'd0);
    chk("midreset_ferr",   {31'd0, rx_if.o_Rx_Frame_Err}, 32'd0);
    #(TCLK - 1);
    rst = 1'b0;
    last_good = 8'h00;
    idle_bits(3);
    send_frame(8'h7E, 1'b1, TBIT);
    idle_bits(2);

    // Transmitter 2% slow.
    send_frame(8'h96, 1'b1, 816);
    rx_if.i_Rx_Serial = 1'b1;

    // Drain with a bounded wait.
    for (int i = 0; i < 200; i++) begin
      if (sb_q.size() == 0) break;
      @(negedge clk);
    end
    repeat (4) @(negedge clk);
    chk("scoreboard_drained", sb_q.size(), 32'd0);
    chk("dv_pulse_count", n_dv_seen, n_dv_exp);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 UART receiver: 8 data bits, LSB first, one start bit, one stop bit, no parity.
- It is the receive-side counterpart of the uart_tx transmitter and uses the same CLKS_PER_BIT baud scheme.
- Samples the asynchronous serial line at mid-bit, presents each received byte with a one-cycle valid strobe, and flags framing errors.
- Sits between the board RX pin and the command/packet logic.

Parameters:
- CLKS_PER_BIT, 10'd860, clock cycles per bit = f(i_Clock)/baud. Legal range 4..1023; the clock counter is 10 bits wide.
- HALF_BIT, (CLKS_PER_BIT-1)/2 (integer divide), derived localparam giving the start-bit mid-point.

Ports:
- i_Clock  input  1  system clock, rising-edge.
- i_Reset  input  1  asynchronous, active-high reset.
- i_Rx_Serial  input  1  asynchronous serial line; idles high.
- o_Rx_DV  output  1  one-cycle pulse; o_Rx_Byte is valid while it is high.
- o_Rx_Byte  output  8  last good byte; held until the next good byte.
- o_Rx_Active  output  1  high while a frame is in progress.
- o_Rx_Frame_Err  output  1  one-cycle pulse when the stop bit is sampled low.

Behaviour:
- Reset (async, while i_Reset=1):
  - state=IDLE, synchronizer flops=1, counter=0, bit index=0, shift register=0.
  - o_Rx_DV=0, o_Rx_Byte=0, o_Rx_Active=0, o_Rx_Frame_Err=0.
  - Reset mid-frame abandons the frame with no DV and no error pulse.
- Input synchronizer: 2-flop chain on i_Rx_Serial. All logic uses the synced value rx_s, which lags the pin by 2 cycles.
- Counter is 10-bit and returns to 0 on every state change.
- States:
  - IDLE: counter=0, bit index=0. rx_s=0 -> START, and o_Rx_Active goes 1 on entry.
  - START: count up to HALF_BIT. At count==HALF_BIT:
    - rx_s=0 -> DATA, counter=0.
    - rx_s=1 -> IDLE, o_Rx_Active=0 (glitch rejected, no pulse).
  - DATA: count up to CLKS_PER_BIT-1. At that count:
    - shift_reg[bit_index] <= rx_s; counter=0.
    - bit_index<7 -> increment and stay in DATA; else bit_index=0 and go to STOP.
    - Sample points therefore land HALF_BIT+k*CLKS_PER_BIT cycles after START entry, k=1..8.
  - STOP: count up to CLKS_PER_BIT-1, then sample rx_s:
    - rx_s=1 -> o_Rx_Byte<=shift_reg, o_Rx_DV=1 for the next cycle only, then CLEANUP.
    - rx_s=0 -> o_Rx_Frame_Err=1 for the next cycle only, o_Rx_Byte unchanged, no DV, then BREAK_WAIT.
    - o_Rx_Active goes 0 on STOP exit in both cases.
  - CLEANUP: 1 cycle, then IDLE. A new start bit can be detected from the IDLE cycle that follows.
  - BREAK_WAIT: stay until rx_s=1, then IDLE. A held-low line (break) yields exactly one error pulse and no false frames.
  - Any undefined state -> IDLE.
- o_Rx_DV and o_Rx_Frame_Err are never high in the same cycle, and neither lasts more than one cycle.
- Back-to-back frames: a start bit that immediately follows the stop bit is received, because the stop sample leaves about half a bit of margin before the next start edge.
- Baud tolerance: bytes are received correctly with up to ±2% clock mismatch between transmitter and receiver.

Test Plan:
- Single good byte: CLKS_PER_BIT=8, drive 0xA5 as 8N1 at 8 clk/bit -> exactly one o_Rx_DV pulse, o_Rx_Byte=0xA5, o_Rx_Frame_Err never high, o_Rx_Active high only during the frame.
- Back-to-back: frames 0x00, 0xFF, 0x3C sent with no idle gap -> three DV pulses with bytes 0x00, 0xFF, 0x3C in order.
- Start glitch: line low for 3 cycles (less than HALF_BIT+2), then high -> no DV and no error; o_Rx_Active pulses high then returns to 0; next valid frame 0x81 -> DV with 0x81.
- Framing error / break: frame 0x55 with the stop bit driven 0, line held low for 40 cycles, then high, then frame 0x12 -> one Frame_Err pulse, o_Rx_Byte keeps its previous value, then DV with 0x12.
- Reset mid-frame: assert i_Reset for 1 cycle during data bit 4 of 0xC3 -> all outputs 0 immediately (async), no DV; next frame 0x7E -> DV with 0x7E.
- Baud skew: transmit 0x96 at 8.16 clk/bit (+2%, via testbench fractional timing) -> DV with 0x96.
